// File: rtl/game_progress.sv
// game_progress: round/lives tracker driving a seven-segment field display with
// idle, play, blinking victory and steady defeat screens.
module game_progress #(
  parameter int NUM_DIGITS   = 4,
  parameter int WIN_ROUNDS   = 3,
  parameter int START_LIVES  = 7,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    round_won,
  input  logic                    round_lost,
  output logic [5*NUM_DIGITS-1:0] bits,
  output logic                    victoryflag,
  output logic                    defeatflag,
  output logic [3:0]              lives,
  output logic [3:0]              rounds
);
  localparam int BW = BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, PLAY, VICTORY, DEFEAT} state_t;
  state_t state, state_nx;
  logic [3:0] lives_nx, rounds_nx;
  logic [BW-1:0] blink_cnt, blink_nx;
  logic blank, blank_nx;
  function automatic logic [5*NUM_DIGITS-1:0] disp(input state_t s, input logic [3:0] l, r, input logic b);
    logic [5*NUM_DIGITS-1:0] d;
    d = {NUM_DIGITS{5'b10000}};
    d[4:0] = s == IDLE ? 5'b11111 : {1'b0, r};
    d[5*NUM_DIGITS-1 -: 5] = s == IDLE ? 5'b11111 : {1'b0, l};
    return (s == VICTORY && b) ? '1 : d;
  endfunction
  always_comb begin
    state_nx  = state;
    lives_nx  = lives;
    rounds_nx = rounds;
    blink_nx  = '0;
    blank_nx  = 1'b0;
    case (state)
      PLAY: begin
        if (round_won && !round_lost) begin
          rounds_nx = rounds + 4'd1;
          state_nx  = rounds_nx == 4'(WIN_ROUNDS) ? VICTORY : PLAY;
        end else if (round_lost && !round_won) begin
          lives_nx = lives - 4'd1;
          state_nx = lives_nx == 4'd0 ? DEFEAT : PLAY;
        end
      end
      VICTORY: begin
        blink_nx = blink_cnt == BW'(BLINK_CYCLES - 1) ? '0 : blink_cnt + 1'b1;
        blank_nx = blink_cnt == BW'(BLINK_CYCLES - 1) ? ~blank : blank;
      end
      default: ;
    endcase
    // start restarts from any non-PLAY state and wins over round pulses
    if (start && state != PLAY) begin
      state_nx  = PLAY;
      lives_nx  = 4'(START_LIVES);
      rounds_nx = 4'd0;
      blink_nx  = '0;
      blank_nx  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lives       <= 4'd0;
      rounds      <= 4'd0;
      blink_cnt   <= '0;
      blank       <= 1'b0;
      victoryflag <= 1'b0;
      defeatflag  <= 1'b0;
      bits        <= disp(IDLE, 4'd0, 4'd0, 1'b0);
    end else begin
      state       <= state_nx;
      lives       <= lives_nx;
      rounds      <= rounds_nx;
      blink_cnt   <= blink_nx;
      blank       <= blank_nx;
      victoryflag <= state_nx == VICTORY;
      defeatflag  <= state_nx == DEFEAT;
      bits        <= disp(state_nx, lives_nx, rounds_nx, blank_nx);
    end
  end
endmodule

// File: tb/tb_game_progress.sv
// tb_game_progress: scoreboard bench for game_progress (4-digit with short blink, plus a 6-digit instance).
module tb_game_progress;
  logic clk, reset_n, start, round_won, round_lost;
  logic [19:0] bits;
  logic [29:0] bits6;
  logic victoryflag, defeatflag, victoryflag6, defeatflag6;
  logic [3:0] lives, rounds, lives6, rounds6;
  int n_tests = 0, n_fail = 0;
  typedef struct {logic [19:0] b; logic [3:0] l, r; logic v, d;} exp_t;
  exp_t q[$];
  localparam logic [19:0] IDLE4 = 20'b11111_10000_10000_11111;
  localparam logic [29:0] IDLE6 = {5'b11111, {4{5'b10000}}, 5'b11111};

  game_progress #(.BLINK_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .round_won(round_won), .round_lost(round_lost),
    .bits(bits), .victoryflag(victoryflag), .defeatflag(defeatflag), .lives(lives), .rounds(rounds));
  game_progress #(.NUM_DIGITS(6)) dut6 (
    .clk(clk), .reset_n(reset_n), .start(start), .round_won(round_won), .round_lost(round_lost),
    .bits(bits6), .victoryflag(victoryflag6), .defeatflag(defeatflag6), .lives(lives6), .rounds(rounds6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] pf(input logic [3:0] l, input logic [3:0] r);
    return {1'b0, l, 10'b10000_10000, 1'b0, r};
  endfunction

  task automatic step(input logic s, input logic w, input logic lo, input logic [19:0] eb,
                      input logic [3:0] el, input logic [3:0] er, input logic ev, input logic ed);
    exp_t e;
    start = s; round_won = w; round_lost = lo;
    e = '{eb, el, er, ev, ed};
    q.push_back(e);
    @(negedge clk);
    start = 1'b0; round_won = 1'b0; round_lost = 1'b0;
    if (q.size() == 0) check("sb_empty", 32'd1, 32'd0);
    else begin
      e = q.pop_front();
      check("bits", 32'(bits), 32'(e.b));
      check("lives", 32'(lives), 32'(e.l));
      check("rounds", 32'(rounds), 32'(e.r));
      check("victory", 32'(victoryflag), 32'(e.v));
      check("defeat", 32'(defeatflag), 32'(e.d));
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; round_won = 1'b0; round_lost = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_bits", 32'(bits), 32'(IDLE4));
    check("rst_lives", 32'(lives), 32'd0);
    check("rst_flags", 32'({victoryflag, defeatflag}), 32'd0);
    check("rst_bits6", 32'(bits6), 32'(IDLE6));
    reset_n = 1'b1;
    @(negedge clk);
    step(1, 0, 0, pf(7, 0), 7, 0, 0, 0);
    check("play_bits6", 32'(bits6), 32'({5'b00111, {4{5'b10000}}, 5'b00000}));
    step(0, 1, 1, pf(7, 0), 7, 0, 0, 0);
    step(1, 0, 0, pf(7, 0), 7, 0, 0, 0);
    step(0, 1, 0, pf(7, 1), 7, 1, 0, 0);
    step(0, 1, 0, pf(7, 2), 7, 2, 0, 0);
    step(0, 1, 0, pf(7, 3), 7, 3, 1, 0);
    for (int i = 0; i < 10; i++)
      step(0, 1'(i == 1), 1'(i == 1), (((i + 1) / 4) % 2) ? 20'hFFFFF : pf(7, 3), 7, 3, 1, 0);
    step(1, 0, 0, pf(7, 0), 7, 0, 0, 0);
    for (int i = 6; i >= 1; i--) step(0, 0, 1, pf(4'(i), 0), 4'(i), 0, 0, 0);
    step(0, 0, 1, pf(0, 0), 0, 0, 0, 1);
    step(0, 1, 0, pf(0, 0), 0, 0, 0, 1);
    step(1, 1, 0, pf(7, 0), 7, 0, 0, 0);
    step(0, 1, 0, pf(7, 1), 7, 1, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    check("async_bits", 32'(bits), 32'(IDLE4));
    check("async_lives", 32'(lives), 32'd0);
    check("async_rounds", 32'(rounds), 32'd0);
    check("async_bits6", 32'(bits6), 32'(IDLE6));
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 1, 0, pf(7, 0), 7, 0, 0, 0);
    step(0, 1, 0, pf(7, 1), 7, 1, 0, 0);
    step(0, 1, 0, pf(7, 2), 7, 2, 0, 0);
    step(0, 1, 0, pf(7, 3), 7, 3, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, i == 3 ? 20'hFFFFF : pf(7, 3), 7, 3, 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
